lif_sensory_neuron: RTL and testbench

//   Parametrised leaky integrate-and-fire sensory neuron; successor to the fixed 7-bit threshold neuron.

---
 rtl/lif_sensory_neuron.sv | 148 ++++++++++++++
 tb/tb_lif_sensory_neuron.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lif_sensory_neuron.sv
// lif_sensory_neuron
//   Leaky integrate-and-fire sensory neuron. Each integrate cycle the membrane
//   potential loses v >> LEAK_SHIFT, gains the input sample d, and saturates at
//   2^ACC_W-1. When the potential reaches the threshold, the neuron emits a
//   one-cycle spike, clears v and stays silent for REFRACT_CYC cycles.
//
//   Optional feature macro: SPIKE_COUNT_EN adds a saturating spike counter
//   (spike_cnt), which is cleared on reset and on every IDLE->INTEG transition.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   start      in   1       enable; low forces IDLE (highest priority)
//   d          in   DATA_W  input sample, integrated in INTEG
//   th         in   ACC_W   firing threshold, 0 disables firing
//   y          out  1       registered one-cycle spike
//   v          out  ACC_W   registered membrane potential
//   refr       out  1       high while in REFR
//   spike_cnt  out  CNT_W   saturating spike count (SPIKE_COUNT_EN only)
//
// state | meaning
// IDLE  | disabled, v=0; one cycle here before integration starts
// INTEG | leak + accumulate each cycle, fire on v_nx >= th
// REFR  | refractory hold-off, v=0, d ignored
module lif_sensory_neuron #(
  parameter int DATA_W      = 7,
  parameter int ACC_W       = 10,
  parameter int LEAK_SHIFT  = 3,
  parameter int REFRACT_CYC = 4,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] d,
  input  logic [ACC_W-1:0]  th,
  output logic              y,
  output logic [ACC_W-1:0]  v,
  output logic              refr
`ifdef SPIKE_COUNT_EN
  ,
  output logic [CNT_W-1:0]  spike_cnt
`endif
);

  localparam int RC_W = (REFRACT_CYC > 0) ? $clog2(REFRACT_CYC + 1) : 1;
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(REFRACT_CYC);
  localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INTEG = 2'd1,
    REFR  = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [RC_W-1:0] rcnt, rcnt_nx;
  logic [ACC_W-1:0] v_nx;
  logic             y_nx;

  logic [ACC_W-1:0] leak;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] v_int;
  logic             fire;

  // leak <= v, so the subtraction cannot borrow; only the add can overflow
  assign leak  = v >> LEAK_SHIFT;
  assign sum   = {1'b0, v} - {1'b0, leak} + (ACC_W+1)'(d);
  assign v_int = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  assign fire  = (th != '0) && (v_int >= th);

  always_comb begin
    state_nx = state;
    rcnt_nx  = rcnt;
    v_nx     = v;
    y_nx     = 1'b0;
    if (!start) begin
      state_nx = IDLE;
      rcnt_nx  = '0;
      v_nx     = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = INTEG;
          v_nx     = '0;
        end
        INTEG: begin
          if (fire) begin
            y_nx = 1'b1;
            v_nx = '0;
            if (REFRACT_CYC == 0) begin
              state_nx = INTEG;
            end else begin
              state_nx = REFR;
              rcnt_nx  = RC_LOAD;
            end
          end else begin
            v_nx = v_int;
          end
        end
        REFR: begin
          v_nx = '0;
          // the edge that takes the count to zero is also the edge into INTEG
          if (rcnt <= RC_ONE) begin
            state_nx = INTEG;
            rcnt_nx  = '0;
          end else begin
            rcnt_nx = rcnt - RC_ONE;
          end
        end
        default: begin
          state_nx = IDLE;
          rcnt_nx  = '0;
          v_nx     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rcnt  <= '0;
      v     <= '0;
      y     <= 1'b0;
    end else begin
      state <= state_nx;
      rcnt  <= rcnt_nx;
      v     <= v_nx;
      y     <= y_nx;
    end
  end

  assign refr = (state == REFR);

`ifdef SPIKE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_cnt <= '0;
    end else if (start && (state == IDLE)) begin
      spike_cnt <= '0;
    end else if (y_nx && (spike_cnt != {CNT_W{1'b1}})) begin
      spike_cnt <= spike_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_lif_sensory_neuron.sv
module tb_lif_sensory_neuron;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] d     = '0;
  logic [9:0] th    = '0;
  logic       y;
  logic [9:0] v;
  logic       refr;
`ifdef SPIKE_COUNT_EN
  localparam int CW = 2;
  logic [CW-1:0] spike_cnt;
`else
  localparam int CW = 8;
`endif

  lif_sensory_neuron #(
    .DATA_W(7), .ACC_W(10), .LEAK_SHIFT(3), .REFRACT_CYC(4), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .d(d), .th(th),
    .y(y), .v(v), .refr(refr)
`ifdef SPIKE_COUNT_EN
    , .spike_cnt(spike_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       s;
    logic [6:0] dd;
    logic [9:0] tt;
    logic       ey;
    logic [9:0] ev;
    logic       er;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic s, input int dd, input int tt,
                              input logic ey, input int ev, input logic er);
    vec_t r;
    r.s = s; r.dd = 7'(dd); r.tt = 10'(tt);
    r.ey = ey; r.ev = 10'(ev); r.er = er;
    vecs.push_back(r);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_range(input string nm, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input int dd, input int tt);
    start = s; d = 7'(dd); th = 10'(tt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ysum;
    int vprev;
    int wraps;
    // fire / refractory, period 5
    add(1, 100, 5, 0, 0, 0);
    add(1, 100, 5, 1, 0, 1);
    add(1, 100, 5, 0, 0, 1);
    add(1, 100, 5, 0, 0, 1);
    add(1, 100, 5, 0, 0, 1);
    add(1, 100, 5, 0, 0, 0);
    add(1, 100, 5, 1, 0, 1);
    add(0, 100, 5, 0, 0, 0);
    // leak trajectory
    add(1, 20, 200, 0, 0, 0);
    add(1, 20, 200, 0, 20, 0);
    add(1, 20, 200, 0, 38, 0);
    add(1, 20, 200, 0, 54, 0);
    add(1, 20, 200, 0, 68, 0);
    add(1, 20, 200, 0, 80, 0);
    add(1, 20, 200, 0, 90, 0);
    add(1, 20, 200, 0, 99, 0);
    add(0, 20, 200, 0, 0, 0);
    // abort in REFR cycle 2, restart has no leftover refractory
    add(1, 100, 5, 0, 0, 0);
    add(1, 100, 5, 1, 0, 1);
    add(1, 100, 5, 0, 0, 1);
    add(0, 100, 5, 0, 0, 0);
    add(1, 100, 5, 0, 0, 0);
    add(1, 100, 5, 1, 0, 1);
    // threshold boundary: v_nx == th fires, v_nx == th-1 does not
    add(0, 20, 20, 0, 0, 0);
    add(1, 20, 20, 0, 0, 0);
    add(1, 20, 20, 1, 0, 1);
    add(0, 20, 21, 0, 0, 0);
    add(1, 20, 21, 0, 0, 0);
    add(1, 20, 21, 0, 20, 0);
    add(1, 20, 21, 1, 0, 1);
    add(0, 20, 21, 0, 0, 0);

    #2;
    chk("reset_y", int'(y), 0);
    chk("reset_v", int'(v), 0);
    chk("reset_refr", int'(refr), 0);
    #10 rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].s, int'(vecs[i].dd), int'(vecs[i].tt));
      tick();
      chk($sformatf("vec%0d_y", i), int'(y), int'(vecs[i].ey));
      chk($sformatf("vec%0d_v", i), int'(v), int'(vecs[i].ev));
      chk($sformatf("vec%0d_refr", i), int'(refr), int'(vecs[i].er));
    end

    // leak equilibrium: settles in [160,167] without firing
    drive(1, 20, 200);
    tick();
    ysum = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      ysum += int'(y);
    end
    chk("equil_no_spike", ysum, 0);
    chk_range("equil_v", int'(v), 160, 167);
    vprev = int'(v);
    tick();
    chk("equil_stable", int'(v), vprev);

    // disabled neuron: th=0, full-scale input, no spike, no wrap
    drive(0, 127, 0);
    tick();
    drive(1, 127, 0);
    ysum = 0; wraps = 0; vprev = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      ysum += int'(y);
      if (int'(v) < vprev) wraps++;
      vprev = int'(v);
    end
    chk("disabled_no_spike", ysum, 0);
    chk("disabled_no_wrap", wraps, 0);
    chk_range("disabled_v", int'(v), 1016, 1023);

    // async reset mid-INTEG
    drive(0, 20, 200);
    tick();
    drive(1, 20, 200);
    tick(); tick(); tick(); tick();
    chk("pre_reset_v", int'(v), 54);
    #3 rst_n = 1'b0;
    #1;
    chk("async_v", int'(v), 0);
    chk("async_y", int'(y), 0);
    chk("async_refr", int'(refr), 0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_reset_idle_v", int'(v), 0);
    tick();
    chk("post_reset_integ_v", int'(v), 20);

`ifdef SPIKE_COUNT_EN
    begin
      int nsp;
      int expc;
      drive(0, 100, 5);
      tick();
      drive(1, 100, 5);
      tick();
      chk("cnt_cleared", int'(spike_cnt), 0);
      nsp = 0;
      for (int k = 0; k < 30; k++) begin
        tick();
        if (y) begin
          nsp++;
          expc = (nsp > 3) ? 3 : nsp;
          chk($sformatf("cnt_spike%0d", nsp), int'(spike_cnt), expc);
        end
      end
      chk("cnt_num_spikes", nsp, 6);
      drive(0, 100, 5);
      tick();
      chk("cnt_hold_idle", int'(spike_cnt), 3);
      drive(1, 100, 5);
      tick();
      chk("cnt_restart", int'(spike_cnt), 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
